// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU datapath: op encodings, the result-stage
// state type and the status flag bundle.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    TWO
  } stage_state_t;

  typedef struct packed {
    logic zero;
    logic neg;
    logic par;
  } flags_t;

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational status flags for a logic-unit result. The flags cover zero,
// sign and odd parity only, because logic ops never produce carry or overflow.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] y,
  output flags_t           flags
);

  assign flags.zero = (y == '0);
  assign flags.neg  = y[WIDTH-1];
  assign flags.par  = ^y;

endmodule

// File: rtl/alu_result_stage.sv
// Registered output stage behind logic_8bit: a main register plus a skid entry,
// with flags captured on entry. Optional stats counters: ALU_RESULT_STATS_EN.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OPW   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_y,
  input  logic [OPW-1:0]   in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_y,
  output logic [OPW-1:0]   out_op,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_par
`ifdef ALU_RESULT_STATS_EN
  ,
  input  logic             stat_clr,
  output logic [15:0]      stat_count,
  output logic [15:0]      stat_zero_count
`endif
);

  stage_state_t     state;
  flags_t           in_flags;
  flags_t           main_flags;
  logic             skid_valid;
  logic [WIDTH-1:0] skid_y;
  logic [OPW-1:0]   skid_op;
  flags_t           skid_flags;
  logic             accept;
  logic             drain;

  alu_flag_gen #(.WIDTH(WIDTH)) u_flag_gen (
    .y     (in_y),
    .flags (in_flags)
  );

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  assign out_zero = main_flags.zero;
  assign out_neg  = main_flags.neg;
  assign out_par  = main_flags.par;

  // in_ready is registered as !skid_valid so upstream never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= EMPTY;
      out_valid  <= 1'b0;
      out_y      <= '0;
      out_op     <= '0;
      main_flags <= '0;
      skid_valid <= 1'b0;
      skid_y     <= '0;
      skid_op    <= '0;
      skid_flags <= '0;
      in_ready   <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            out_y      <= in_y;
            out_op     <= in_op;
            main_flags <= in_flags;
            out_valid  <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            out_y      <= in_y;
            out_op     <= in_op;
            main_flags <= in_flags;
          end else if (accept) begin
            skid_y     <= in_y;
            skid_op    <= in_op;
            skid_flags <= in_flags;
            skid_valid <= 1'b1;
            in_ready   <= 1'b0;
            state      <= TWO;
          end else if (drain) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            out_y      <= skid_y;
            out_op     <= skid_op;
            main_flags <= skid_flags;
            skid_valid <= 1'b0;
            in_ready   <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state <= EMPTY;
        end
      endcase
    end
  end

`ifdef ALU_RESULT_STATS_EN
  // Clear takes priority over a same-cycle increment; both counters saturate.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_count      <= '0;
      stat_zero_count <= '0;
    end else if (accept) begin
      if (stat_count != 16'hFFFF)
        stat_count <= stat_count + 16'd1;
      if (in_flags.zero && (stat_zero_count != 16'hFFFF))
        stat_zero_count <= stat_zero_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: accepted results are queued with flags
// derived arithmetically, and a negedge monitor checks every presented output.
module tb_alu_result_stage;
  import alu_pkg::*;

  localparam int WIDTH = ALU_WIDTH;
  localparam int OPW   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_y;
  logic [OPW-1:0]   in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [OPW-1:0]   out_op;
  logic             out_zero;
  logic             out_neg;
  logic             out_par;
`ifdef ALU_RESULT_STATS_EN
  logic             stat_clr;
  logic [15:0]      stat_count;
  logic [15:0]      stat_zero_count;
  int unsigned      m_cnt = 0;
  int unsigned      m_zc  = 0;
`endif

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic [OPW-1:0]   op;
  } item_t;

  item_t exp_q[$];
  item_t head;
  bit    mon_en = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;

  alu_result_stage #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_y      (in_y),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_op    (out_op),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_par   (out_par)
`ifdef ALU_RESULT_STATS_EN
    ,
    .stat_clr        (stat_clr),
    .stat_count      (stat_count),
    .stat_zero_count (stat_zero_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare the presented entry with the queue head, then account for this cycle's handshakes.
  always @(negedge clk) begin
    if (mon_en) begin
      check_output("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      check_output("in_ready", {31'd0, in_ready}, {31'd0, exp_q.size() < 2});
      if (out_valid && exp_q.size() > 0) begin
        head = exp_q[0];
        check_output("out_y", 32'(out_y), 32'(head.y));
        check_output("out_op", 32'(out_op), 32'(head.op));
        check_output("out_zero", {31'd0, out_zero}, {31'd0, head.y == 0});
        check_output("out_neg", {31'd0, out_neg}, {31'd0, head.y >= 8'h80});
        check_output("out_par", {31'd0, out_par}, {31'd0, ($countones(head.y) % 2) == 1});
      end
`ifdef ALU_RESULT_STATS_EN
      check_output("stat_count", 32'(stat_count), m_cnt);
      check_output("stat_zero_count", 32'(stat_zero_count), m_zc);
      if (rst || stat_clr) begin
        m_cnt = 0;
        m_zc  = 0;
      end else if (in_valid && in_ready) begin
        if (m_cnt < 65535) m_cnt++;
        if (in_y == 0 && m_zc < 65535) m_zc++;
      end
`endif
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (in_valid && in_ready) exp_q.push_back('{y: in_y, op: in_op});
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v, input logic [WIDTH-1:0] y,
                                input logic [OPW-1:0] op, input logic rdy);
    in_valid  = v;
    in_y      = y;
    in_op     = op;
    out_ready = rdy;
    next_cycle();
  endtask

  task automatic drain_all();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) next_cycle();
    check_output("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic hold;
    logic taken;
    rst = 1'b1; in_valid = 1'b0; in_y = '0; in_op = '0; out_ready = 1'b0;
`ifdef ALU_RESULT_STATS_EN
    stat_clr = 1'b0;
`endif
    next_cycle();
    mon_en = 1'b1;
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_output("rst_out_y", 32'(out_y), 32'd0);
    check_output("rst_out_op", 32'(out_op), 32'd0);
    check_output("rst_flags", {29'd0, out_zero, out_neg, out_par}, 32'd0);
    next_cycle();
    rst = 1'b0;

    // Single zero result
    apply_stimulus(1'b1, 8'h00, OP_AND, 1'b1);
    in_valid = 1'b0;
    check_output("t1_valid", {31'd0, out_valid}, 32'd1);
    check_output("t1_y", 32'(out_y), 32'h00);
    check_output("t1_flags", {29'd0, out_zero, out_neg, out_par}, 32'b100);
    next_cycle();

    // Back-to-back stream
    apply_stimulus(1'b1, 8'h80, OP_OR, 1'b1);
    check_output("t2_flags_80", {29'd0, out_zero, out_neg, out_par}, 32'b011);
    apply_stimulus(1'b1, 8'h07, OP_XOR, 1'b1);
    check_output("t2_flags_07", {29'd0, out_zero, out_neg, out_par}, 32'b001);
    apply_stimulus(1'b1, 8'hFF, OP_NOT, 1'b1);
    check_output("t2_flags_ff", {29'd0, out_zero, out_neg, out_par}, 32'b010);
    check_output("t2_in_ready", {31'd0, in_ready}, 32'd1);
    drain_all();

    // Back-pressure fills the skid entry
    apply_stimulus(1'b1, 8'h11, OP_AND, 1'b0);
    apply_stimulus(1'b1, 8'h22, OP_OR, 1'b0);
    in_valid = 1'b0;
    check_output("t3_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("t3_hold_y", 32'(out_y), 32'h11);
    next_cycle();
    check_output("t3_hold_y2", 32'(out_y), 32'h11);

    // Upstream holds 8'h33 until the stage can take it
    apply_stimulus(1'b1, 8'h33, OP_XOR, 1'b0);
    out_ready = 1'b1;
    taken = 1'b0;
    for (int i = 0; i < 10 && !taken; i++) begin
      taken = in_ready;
      next_cycle();
    end
    in_valid = 1'b0;
    check_output("t4_accepted", {31'd0, taken}, 32'd1);
    drain_all();

    // Reset while both entries are full, with handshakes active
    apply_stimulus(1'b1, 8'h44, OP_AND, 1'b0);
    apply_stimulus(1'b1, 8'h55, OP_OR, 1'b0);
    rst = 1'b1;
    apply_stimulus(1'b1, 8'h66, OP_XOR, 1'b1);
    rst = 1'b0;
    in_valid = 1'b0;
    check_output("t5_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("t5_in_ready", {31'd0, in_ready}, 32'd1);
    apply_stimulus(1'b1, 8'h5A, OP_XOR, 1'b1);
    in_valid = 1'b0;
    check_output("t5_y", 32'(out_y), 32'h5A);
    check_output("t5_par", {31'd0, out_par}, 32'd0);
    drain_all();

`ifdef ALU_RESULT_STATS_EN
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    apply_stimulus(1'b1, 8'h12, OP_AND, 1'b1);
    apply_stimulus(1'b1, 8'h00, OP_OR, 1'b1);
    apply_stimulus(1'b1, 8'h34, OP_XOR, 1'b1);
    in_valid = 1'b0;
    check_output("stat_three", 32'(stat_count), 32'd3);
    check_output("stat_zero_one", 32'(stat_zero_count), 32'd1);
    stat_clr = 1'b1;
    apply_stimulus(1'b1, 8'h00, OP_AND, 1'b1);
    stat_clr = 1'b0;
    in_valid = 1'b0;
    check_output("stat_clr_count", 32'(stat_count), 32'd0);
    check_output("stat_clr_zero", 32'(stat_zero_count), 32'd0);
    drain_all();
`endif

    // Random traffic; upstream keeps its data while stalled
    for (int i = 0; i < 600; i++) begin
      hold = in_valid && !in_ready;
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_y     = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
        in_op    = 2'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      next_cycle();
    end
    drain_all();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
